// File: rtl/oled_pkg.sv
// Shared OLED panel geometry, RGB565 colour constants and the pixel streamer FSM encoding.
package oled_pkg;

   localparam int OLED_WIDTH  = 96;
   localparam int OLED_HEIGHT = 64;
   localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;

   localparam logic [15:0] RED   = 16'hF800;
   localparam logic [15:0] BLUE  = 16'h001F;
   localparam logic [15:0] WHITE = 16'hFFFF;
   localparam logic [15:0] BLACK = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
      ST_GAP
   } oled_state_e;

endpackage

// File: rtl/spi_shift_tx.sv
// 16-bit MSB-first SPI shifter with SCLK divider; a word takes 32*CLK_DIV cycles from load.
// done is high in the word's final cycle so a same-cycle load keeps the bit stream gapless.
module spi_shift_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_dat,
   output logic        sclk,
   output logic        sdin,
   output logic        done
);

   localparam int DIV_W = $clog2(CLK_DIV) + 1;

   logic [15:0]      shreg_q, shreg_d;
   logic [3:0]       bit_q, bit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             sclk_q, sclk_d;
   logic             act_q, act_d;
   logic             phase_end;

   always_comb begin
      phase_end = (div_q == DIV_W'(CLK_DIV - 1));
      done      = act_q && sclk_q && phase_end && (bit_q == 4'd15);
      shreg_d   = shreg_q;
      bit_d     = bit_q;
      div_d     = div_q;
      sclk_d    = sclk_q;
      act_d     = act_q;
      if (load) begin
         shreg_d = load_dat;
         bit_d   = 4'd0;
         div_d   = '0;
         sclk_d  = 1'b0;
         act_d   = 1'b1;
      end else if (act_q) begin
         if (!phase_end) begin
            div_d = div_q + 1'b1;
         end else begin
            div_d = '0;
            if (!sclk_q) begin
               sclk_d = 1'b1;
            end else begin
               shreg_d = {shreg_q[14:0], 1'b0};
               bit_d   = bit_q + 4'd1;
               // After the last bit SCLK simply stays high, which is its idle level.
               if (bit_q == 4'd15) act_d = 1'b0;
               else                sclk_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shreg_q <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         sclk_q  <= 1'b1;
         act_q   <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         sclk_q  <= sclk_d;
         act_q   <= act_d;
      end
   end

   assign sclk = sclk_q;
   assign sdin = shreg_q[15];

endmodule

// File: rtl/oled_pixel_streamer.sv
// Streams whole frames of RGB565 pixels from the colour pipeline to the OLED over 4-wire SPI.
// The next pixel index is issued one word ahead so its data is ready at the word boundary.
module oled_pixel_streamer
   import oled_pkg::*;
#(
   parameter int WIDTH     = OLED_WIDTH,
   parameter int HEIGHT    = OLED_HEIGHT,
   parameter int CLK_DIV   = 4,
   parameter int PIX_LAT   = 2,
   parameter int FRAME_GAP = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   output logic [12:0] pixel_index,
   input  logic [15:0] pixel_data,
   output logic        oled_cs,
   output logic        oled_sclk,
   output logic        oled_sdin,
   output logic        oled_dc,
   output logic        frame_begin,
   output logic        sending_pixels,
   output logic        busy
);

   localparam int          NPIX     = WIDTH * HEIGHT;
   localparam logic [12:0] LAST_IDX = 13'(NPIX - 1);
   localparam int          CNT_MAX  = (PIX_LAT > FRAME_GAP) ? PIX_LAT : FRAME_GAP;
   localparam int          CNT_W    = $clog2(CNT_MAX + 1) + 1;

   oled_state_e      state_q, state_d;
   logic [12:0]      idx_q, idx_d;
   logic [12:0]      pix_q, pix_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cs_q, cs_d;
   logic             fb_q, fb_d;
   logic             snd_q, snd_d;
   logic             busy_q, busy_d;
   logic             load;
   logic             done;
   logic [13:0]      idx_next2;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pix_d     = pix_q;
      cnt_d     = cnt_q;
      cs_d      = cs_q;
      fb_d      = 1'b0;
      snd_d     = snd_q;
      load      = 1'b0;
      idx_next2 = {1'b0, pix_q} + 14'd2;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_FETCH;
               fb_d    = 1'b1;
               idx_d   = 13'd0;
               cnt_d   = '0;
            end
         end
         ST_FETCH: begin
            // Index 0 was issued on entry; its data has settled once PIX_LAT cycles have passed.
            if (cnt_q == CNT_W'(PIX_LAT)) begin
               load    = 1'b1;
               cs_d    = 1'b0;
               snd_d   = 1'b1;
               pix_d   = 13'd0;
               idx_d   = (LAST_IDX > 13'd0) ? 13'd1 : 13'd0;
               state_d = ST_SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (done) begin
               if (pix_q == LAST_IDX) begin
                  cs_d    = 1'b1;
                  snd_d   = 1'b0;
                  idx_d   = 13'd0;
                  cnt_d   = '0;
                  state_d = ST_GAP;
               end else begin
                  load  = 1'b1;
                  pix_d = pix_q + 13'd1;
                  idx_d = (idx_next2 > {1'b0, LAST_IDX}) ? LAST_IDX : idx_next2[12:0];
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == CNT_W'(FRAME_GAP - 1)) state_d = ST_IDLE;
            else                                cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         pix_q   <= '0;
         cnt_q   <= '0;
         cs_q    <= 1'b1;
         fb_q    <= 1'b0;
         snd_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pix_q   <= pix_d;
         cnt_q   <= cnt_d;
         cs_q    <= cs_d;
         fb_q    <= fb_d;
         snd_q   <= snd_d;
         busy_q  <= busy_d;
      end
   end

   spi_shift_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .load_dat (pixel_data),
      .sclk     (oled_sclk),
      .sdin     (oled_sdin),
      .done     (done)
   );

   assign pixel_index    = idx_q;
   assign oled_cs        = cs_q;
   assign oled_dc        = 1'b1;
   assign frame_begin    = fb_q;
   assign sending_pixels = snd_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer on a reduced 8x4 frame: SPI words decoded and scoreboarded per frame.
module tb_oled_pixel_streamer;

   localparam int W        = 8;
   localparam int H        = 4;
   localparam int NPIX     = W * H;
   localparam int CDIV     = 2;
   localparam int PLAT     = 2;
   localparam int GAP      = 16;
   localparam int WORD_CYC = 32 * CDIV;
   localparam int PERIOD   = 1 + PLAT + NPIX * WORD_CYC + GAP + 1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [12:0] pixel_index;
   logic [15:0] pixel_data = 16'h0;
   logic [15:0] stage1 = 16'h0;
   logic        oled_cs, oled_sclk, oled_sdin, oled_dc;
   logic        frame_begin, sending_pixels, busy;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int toggles = 0;
   int max_idx = 0;
   logic [15:0] sb[$];

   oled_pixel_streamer #(
      .WIDTH     (W),
      .HEIGHT    (H),
      .CLK_DIV   (CDIV),
      .PIX_LAT   (PLAT),
      .FRAME_GAP (GAP)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .pixel_index    (pixel_index),
      .pixel_data     (pixel_data),
      .oled_cs        (oled_cs),
      .oled_sclk      (oled_sclk),
      .oled_sdin      (oled_sdin),
      .oled_dc        (oled_dc),
      .frame_begin    (frame_begin),
      .sending_pixels (sending_pixels),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [15:0] color(input logic [12:0] idx);
      if (idx == 13'd0) return 16'hF800;
      return {3'b000, idx} ^ 16'hA5A5;
   endfunction

   // Upstream colour pipeline: two registered stages from index to data.
   always @(posedge clock) begin
      stage1     <= color(pixel_index);
      pixel_data <= stage1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic wait_until(input string tag, input int sel, input logic val,
                             input int budget, output int t);
      logic s;
      t = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         case (sel)
            0:       s = frame_begin;
            1:       s = oled_cs;
            default: s = busy;
         endcase
         if (s === val) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         chk({"timeout-", tag}, 32'd0, 32'd1);
         t = cyc;
      end
   endtask

   // SPI monitor and scoreboard.
   initial begin
      logic        prev_sclk;
      logic        prev_cs;
      logic [15:0] word;
      int          bits;
      int          frame_rises;
      int          last_rise;
      prev_sclk = 1'b1;
      prev_cs = 1'b1;
      word = 16'h0;
      bits = 0;
      frame_rises = 0;
      last_rise = -1;
      forever begin
         @(negedge clock);
         if (reset) begin
            sb.delete();
            bits = 0;
            word = 16'h0;
            frame_rises = 0;
            last_rise = -1;
            prev_sclk = oled_sclk;
            prev_cs = oled_cs;
         end else begin
            if (oled_sclk !== prev_sclk) toggles++;
            if (int'(pixel_index) > max_idx) max_idx = int'(pixel_index);
            if (frame_begin) for (int i = 0; i < NPIX; i++) sb.push_back(color(13'(i)));
            if (!prev_sclk && oled_sclk && !oled_cs) begin
               if (last_rise >= 0) chk("sclk-period", cyc - last_rise, 2 * CDIV);
               last_rise = cyc;
               frame_rises++;
               word = {word[14:0], oled_sdin};
               bits++;
               if (bits == 16) begin
                  bits = 0;
                  if (sb.size() == 0) chk("sb-underflow", 32'd1, 32'd0);
                  else chk("word", word, sb.pop_front());
                  chk("sending", sending_pixels, 1);
               end
            end
            if (!prev_cs && oled_cs) begin
               chk("rises/frame", frame_rises, NPIX * 16);
               chk("sb-left", sb.size(), 0);
               frame_rises = 0;
               last_rise = -1;
               bits = 0;
            end
            prev_sclk = oled_sclk;
            prev_cs = oled_cs;
         end
      end
   end

   initial begin
      int t0, t1, t2, t3, t4, tcs, tog0, nfb;

      // Reset and idle with enable low.
      repeat (3) @(negedge clock);
      chk("rst-cs", oled_cs, 1);
      chk("rst-sclk", oled_sclk, 1);
      chk("rst-busy", busy, 0);
      chk("rst-idx", pixel_index, 0);
      chk("rst-sdin", oled_sdin, 0);
      chk("rst-dc", oled_dc, 1);
      reset = 1'b0;
      tog0 = toggles;
      repeat (100) @(negedge clock);
      chk("idle-cs", oled_cs, 1);
      chk("idle-sclk", oled_sclk, 1);
      chk("idle-busy", busy, 0);
      chk("idle-idx", pixel_index, 0);
      chk("idle-fb", frame_begin, 0);
      chk("idle-toggles", toggles - tog0, 0);

      // First frame: start latency, prefetch index, end-of-frame state and gap.
      enable = 1'b1;
      wait_until("fb1", 0, 1'b1, 10, t0);
      chk("fb1-idx", pixel_index, 0);
      @(negedge clock);
      chk("fb-pulse", frame_begin, 0);
      wait_until("cs-low", 1, 1'b0, 10, tcs);
      chk("cs-delay", tcs - t0, PLAT + 1);
      chk("cs-snd", sending_pixels, 1);
      chk("cs-busy", busy, 1);
      chk("cs-dc", oled_dc, 1);
      chk("prefetch-idx", pixel_index, 1);
      wait_until("cs-high", 1, 1'b1, NPIX * WORD_CYC + 10, t1);
      chk("eof-sclk", oled_sclk, 1);
      chk("eof-snd", sending_pixels, 0);
      chk("eof-idx", pixel_index, 0);
      chk("eof-busy", busy, 1);
      wait_until("gap-end", 2, 1'b0, GAP + 10, t2);
      chk("gap-len", t2 - t1, GAP);

      // Back-to-back frames with enable held: constant frame period.
      wait_until("fb2", 0, 1'b1, 10, t3);
      chk("period1", t3 - t0, PERIOD);
      wait_until("fb3", 0, 1'b1, PERIOD + 10, t4);
      chk("period2", t4 - t3, PERIOD);

      // Drop enable mid-frame: frame completes, no further frame starts.
      wait_until("cs-low3", 1, 1'b0, 10, tcs);
      repeat (16 * WORD_CYC) @(negedge clock);
      enable = 1'b0;
      wait_until("cs-high3", 1, 1'b1, NPIX * WORD_CYC + 10, t1);
      wait_until("busy-low3", 2, 1'b0, GAP + 10, t2);
      nfb = 0;
      for (int i = 0; i < 2 * PERIOD; i++) begin
         @(negedge clock);
         if (frame_begin) nfb++;
      end
      chk("no-restart", nfb, 0);
      chk("stop-busy", busy, 0);

      // Asynchronous reset in the middle of pixel 10, bit 7.
      enable = 1'b1;
      wait_until("fb4", 0, 1'b1, 10, t0);
      wait_until("cs-low4", 1, 1'b0, 10, tcs);
      repeat (10 * WORD_CYC + 7 * 2 * CDIV + 1) @(negedge clock);
      chk("pre-rst-cs", oled_cs, 0);
      chk("pre-rst-busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst-cs", oled_cs, 1);
      chk("arst-sclk", oled_sclk, 1);
      chk("arst-busy", busy, 0);
      chk("arst-idx", pixel_index, 0);
      chk("arst-snd", sending_pixels, 0);
      chk("arst-sdin", oled_sdin, 0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      wait_until("fb5", 0, 1'b1, 10, t0);
      chk("fb5-idx", pixel_index, 0);
      wait_until("cs-low5", 1, 1'b0, 10, tcs);
      enable = 1'b0;
      wait_until("cs-high5", 1, 1'b1, NPIX * WORD_CYC + 10, t1);
      wait_until("busy-low5", 2, 1'b0, GAP + 10, t2);
      chk("final-sb", sb.size(), 0);
      chk("max-idx", max_idx, NPIX - 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/oled_pixel_streamer.md
Name: oled_pixel_streamer

Overview:
- Display-side transmitter for the pixel interface of the 96x64 OLED.
- Drives pixel_index, samples the returned 16-bit RGB565 pixel_data and serialises it over a 4-wire SPI link (CS, SCLK, SDIN, D/C) to the SSD1331-class panel.
- It is the consumer end of the index→colour path used by the border/overlay generators.
- Frames stream continuously while enable is high.

Parameters:
- WIDTH, 96, pixels per row.
- HEIGHT, 64, rows per frame; last index = WIDTH*HEIGHT-1 = 6143.
- CLK_DIV, 4, clock cycles per SCLK half-period (min 1).
- PIX_LAT, 2, clock cycles from a pixel_index change to valid pixel_data (upstream registered stages); must be < 32*CLK_DIV.
- FRAME_GAP, 16, clock cycles CS is held high between frames.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  start/continue frame streaming
- pixel_index  out  13  pixel address requested from the colour pipeline (row-major, x = idx%96, y = idx/96)
- pixel_data  in  16  RGB565 colour for pixel_index, valid PIX_LAT cycles after it changes
- oled_cs  out  1  SPI chip select, active low
- oled_sclk  out  1  SPI clock, idles high; panel samples on rising edge
- oled_sdin  out  1  SPI data, MSB first
- oled_dc  out  1  data/command select; tied to 1 (data) in this block
- frame_begin  out  1  one-cycle pulse when index 0 is first issued for a frame
- sending_pixels  out  1  high from the first CS-low cycle to the last SCLK rise of the frame
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate, including mid-frame):
  - State = IDLE.
  - pixel_index = 0, oled_cs = 1, oled_sclk = 1, oled_sdin = 0, oled_dc = 1.
  - frame_begin = 0, sending_pixels = 0, busy = 0.
  - Shift register, bit counter, divider counter and gap counter = 0.
- FSM states: IDLE, FETCH, SHIFT, GAP.
- IDLE:
  - enable = 0: stay, outputs at reset values.
  - enable = 1: next cycle frame_begin = 1 for exactly one cycle, pixel_index = 0, go FETCH.
- FETCH:
  - Count PIX_LAT cycles.
  - On the PIX_LAT-th cycle: load the shift register with pixel_data, oled_cs = 0, sending_pixels = 1, pixel_index = 1 (prefetch), go SHIFT.
- SHIFT:
  - Each bit takes 2*CLK_DIV cycles.
  - Bit is placed on oled_sdin while oled_sclk = 0 for CLK_DIV cycles, then oled_sclk = 1 for CLK_DIV cycles.
  - oled_sdin is stable across each rising edge.
  - 16 bits per pixel, bit 15 first.
  - At the end of bit 0 of pixel N (N < 6143): load shift register from pixel_data (the value for N+1, already valid via prefetch) and set pixel_index = N+2, saturating at 6143.
  - No idle SCLK period between pixels; the bit stream is gapless across the frame.
- End of frame:
  - After the final SCLK high phase of pixel 6143: oled_cs = 1, oled_sclk = 1, sending_pixels = 0, pixel_index = 0, go GAP.
- GAP:
  - Hold FRAME_GAP cycles, then go IDLE.
  - If enable is still 1, the next frame starts as specified for IDLE.
- enable deassert mid-frame: the current frame completes; no new frame starts.
- pixel_data changes between capture points are ignored. Each pixel is captured exactly once per frame.
- Frame length in clock cycles: 1 + PIX_LAT + 6144*16*2*CLK_DIV + FRAME_GAP (+1 IDLE cycle).
  - Defaults: 786,451 + IDLE cycle.
- Counters:
  - Pixel counter: 13 bits, compared against the WIDTH*HEIGHT-1 constant; never wraps past 6143.
  - Bit counter: 4 bits.
  - Divider counter: ceil(log2(CLK_DIV))+1 bits.

Decomposition:
- Shared package oled_pkg: OLED_WIDTH = 96, OLED_HEIGHT = 64, OLED_PIXELS = 6144, the RGB565 colour constants (RED, BLUE, WHITE, BLACK), and the FSM state encoding.
- One natural sub-module: spi_shift_tx. It holds the 16-bit shifter and the SCLK divider, with a load/done handshake (load with 16-bit word → done pulse after 32*CLK_DIV cycles). The top level owns the FSM and pixel counter.

Test Plan:
- Reset/idle: reset = 1, then release with enable = 0 for 100 cycles → oled_cs = 1, oled_sclk = 1, pixel_index = 0, busy = 0, no SCLK edges.
- First pixel: CLK_DIV = 1, PIX_LAT = 2, model returns pixel_data = 0xF800 for index 0; raise enable → frame_begin pulses once; CS falls 3 cycles later; bits sampled on the first 16 SCLK rises = 1111_1000_0000_0000.
- Prefetch/continuity: model returns pixel_data = index ^ 0xA5A5 with a 2-cycle delay → SPI monitor decodes 6144 words equal to i ^ 0xA5A5 in order; SCLK period is constant (2 cycles) with no gaps at word boundaries.
- Frame end and gap: count SCLK rises in one frame = 98,304 exactly; CS high for 16 cycles; with enable held, frame_begin recurs at a fixed period; pixel_index never exceeds 6143.
- Enable drop mid-frame: deassert enable at pixel 3000 → frame completes all 6144 pixels, then busy = 0 and no further frame_begin.
- Async reset mid-shift: assert reset during pixel 100 bit 7, between clock edges → CS, SCLK and busy go to reset values immediately, before the next clock edge; after release with enable = 1 the new frame starts at index 0 with a fresh frame_begin.
